network: RTL and testbench

- Single-layer spiking classifier: HEIGHT binary pixel inputs, each with a signed synaptic weight, drive one leaky integrate-and-fire neuron.
- Each cycle, the weights of the active pixels are summed and integrated into a membrane potential with leak, threshold, reset and refractory period.
- neuron_out is a registered one-cycle spike.
- Instantiated by the run wrapper, which gates its clock for a fixed run window and interprets spikes as the class decision.

---
 rtl/snn_pkg.sv | 20 ++
 rtl/lif_neuron.sv | 41 ++++
 rtl/network.sv | 39 +++
 tb/tb_network.sv | 116 +++++++++++
 4 files changed

// File: rtl/snn_pkg.sv
// snn_pkg: shared helpers for the spiking classifier (weight decode, widths).
package snn_pkg;
   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction
   // Membrane potential width: weight magnitude plus headroom for HEIGHT synapses.
   function automatic int pot_width(input int width, input int height);
      return width + clog2(height) + 1;
   endfunction
   // Sign-magnitude (bit width = sign) to two's-complement integer.
   function automatic int decode_weight(input int w, input int width);
      int mag;
      mag = w & ((1 << width) - 1);
      return ((w >> width) & 1) != 0 ? -mag : mag;
   endfunction
   localparam int DEF_PW = pot_width(8, 7);
endpackage

// File: rtl/lif_neuron.sv
// lif_neuron: leaky integrate-and-fire neuron with clamped potential and refractory hold.
module lif_neuron
   import snn_pkg::*;
#(
   parameter int PW         = DEF_PW,
   parameter int THRESHOLD  = 256,
   parameter int LEAK_SHIFT = 3,
   parameter int REFRACT    = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic signed [PW:0] syn_in,
   output logic              spike
);
   localparam int RW = REFRACT > 0 ? clog2(REFRACT + 1) : 1;
   localparam logic [PW:0] TH = (PW + 1)'(THRESHOLD);
   logic [PW-1:0]        v;
   logic [RW-1:0]        cnt;
   logic signed [PW+1:0] n_raw;
   logic [PW-1:0]        n_clamp;
   logic                 refr;
   logic                 fire;
   always_comb begin
      n_raw   = signed'({2'b00, v - (v >> LEAK_SHIFT)}) + {syn_in[PW], syn_in};
      // Sign bit means underflow; bit PW on a non-negative value means overflow.
      n_clamp = n_raw[PW+1] ? '0 : n_raw[PW] ? '1 : n_raw[PW-1:0];
      refr    = cnt != '0;
      fire    = !refr && ({1'b0, n_clamp} >= TH);
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v     <= '0;
         cnt   <= '0;
         spike <= 1'b0;
      end else begin
         v     <= (refr || fire) ? '0 : n_clamp;
         cnt   <= refr ? cnt - 1'b1 : fire ? RW'(REFRACT) : cnt;
         spike <= fire;
      end
   end
endmodule

// File: rtl/network.sv
// network: pixel-gated signed synapses summed into a single LIF neuron.
module network
   import snn_pkg::*;
#(
   parameter int                          WIDTH      = 8,
   parameter int                          HEIGHT     = 7,
   parameter logic [HEIGHT-1:0][WIDTH:0]  WEIGHTS    = {HEIGHT{9'd260}},
   parameter int                          THRESHOLD  = 2 ** WIDTH,
   parameter int                          LEAK_SHIFT = 3,
   parameter int                          REFRACT    = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [HEIGHT-1:0] pixels,
   output logic              neuron_out
);
   localparam int PW = pot_width(WIDTH, HEIGHT);
   logic signed [PW:0] term [HEIGHT];
   logic signed [PW:0] syn;
   for (genvar i = 0; i < HEIGHT; i++) begin : g_syn
      localparam int WI = decode_weight(int'(WEIGHTS[i]), WIDTH);
      assign term[i] = pixels[i] ? (PW + 1)'(WI) : '0;
   end
   always_comb begin
      syn = '0;
      for (int i = 0; i < HEIGHT; i++) syn = syn + term[i];
   end
   lif_neuron #(
      .PW(PW),
      .THRESHOLD(THRESHOLD),
      .LEAK_SHIFT(LEAK_SHIFT),
      .REFRACT(REFRACT)
   ) u_lif (
      .clk(clk),
      .rst(rst),
      .syn_in(syn),
      .spike(neuron_out)
   );
endmodule

// File: tb/tb_network.sv
// tb_network: directed vector checks of the spiking classifier across four weight configurations.
module tb_network;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [6:0] px0, px1, px2, px3;
   logic o0, o1, o2, o3;
   int total = 0;
   int bad = 0;
   typedef struct {
      logic [6:0] px;
      logic       out;
      int         v;
   } vec_t;
   vec_t tab[12];
   always #5 clk = ~clk;
   network dut0 (.clk(clk), .rst(rst), .pixels(px0), .neuron_out(o0));
   network #(.WEIGHTS({{6{9'd0}}, 9'd100})) dut1 (.clk(clk), .rst(rst), .pixels(px1), .neuron_out(o1));
   network #(.WEIGHTS({7{9'd100}})) dut2 (.clk(clk), .rst(rst), .pixels(px2), .neuron_out(o2));
   network #(.WEIGHTS({7{9'd255}}), .THRESHOLD(4095)) dut3 (.clk(clk), .rst(rst), .pixels(px3), .neuron_out(o3));
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask
   task automatic tick;
      @(posedge clk);
      #1;
   endtask
   initial begin
      int spikes;
      int maxv;
      tab[0]  = '{7'd1, 1'b0, 100};
      tab[1]  = '{7'd1, 1'b0, 188};
      tab[2]  = '{7'd1, 1'b1, 0};
      tab[3]  = '{7'd1, 1'b0, 0};
      tab[4]  = '{7'd1, 1'b0, 0};
      tab[5]  = '{7'd1, 1'b0, 100};
      tab[6]  = '{7'd1, 1'b0, 188};
      tab[7]  = '{7'd0, 1'b0, 165};
      tab[8]  = '{7'd0, 1'b0, 145};
      tab[9]  = '{7'd0, 1'b0, 127};
      tab[10] = '{7'd0, 1'b0, 112};
      tab[11] = '{7'd0, 1'b0, 98};
      px0 = '0; px1 = '0; px2 = '0; px3 = '0;
      repeat (2) tick;
      chk("reset_out0", o0, 0);
      chk("reset_out1", o1, 0);
      chk("reset_v1", dut1.u_lif.v, 0);
      // Negative weights everywhere: potential must stay pinned at zero.
      px0 = 7'h7f;
      rst = 1'b0;
      spikes = 0; maxv = 0;
      for (int k = 0; k < 600; k++) begin
         tick;
         if (o0) spikes++;
         if (int'(dut0.u_lif.v) > maxv) maxv = int'(dut0.u_lif.v);
      end
      chk("neg_spikes", spikes, 0);
      chk("neg_maxv", maxv, 0);
      px0 = '0;
      for (int k = 0; k < 12; k++) begin
         px1 = tab[k].px;
         tick;
         chk($sformatf("seq_out[%0d]", k + 1), o1, tab[k].out);
         chk($sformatf("seq_v[%0d]", k + 1), dut1.u_lif.v, tab[k].v);
      end
      // Leak alone bottoms out at 7 since 7>>3 is 0.
      spikes = 0;
      for (int k = 0; k < 40; k++) begin
         tick;
         if (o1) spikes++;
      end
      chk("decay_spikes", spikes, 0);
      chk("decay_floor_v", dut1.u_lif.v, 7);
      px2 = 7'h7f;
      for (int k = 1; k <= 9; k++) begin
         tick;
         chk($sformatf("all100_out[%0d]", k), o2, (k % 3) == 1);
      end
      px2 = '0;
      px3 = 7'h7f;
      tick;
      chk("sat_v1", dut3.u_lif.v, 1785);
      tick;
      chk("sat_v2", dut3.u_lif.v, 3347);
      tick;
      chk("sat_out3", o3, 1);
      chk("sat_v3", dut3.u_lif.v, 0);
      px3 = '0;
      rst = 1'b1;
      tick;
      rst = 1'b0;
      px1 = 7'd1;
      tick;
      tick;
      chk("pre_rst_v", dut1.u_lif.v, 188);
      #2 rst = 1'b1;
      #1;
      chk("async_rst_v", dut1.u_lif.v, 0);
      chk("async_rst_out", o1, 0);
      tick;
      chk("held_rst_v", dut1.u_lif.v, 0);
      rst = 1'b0;
      tick;
      chk("rst_e1_out", o1, 0);
      chk("rst_e1_v", dut1.u_lif.v, 100);
      tick;
      chk("rst_e2_out", o1, 0);
      tick;
      chk("rst_e3_out", o1, 1);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
